retire_unit: RTL

//  In-order commit stage of the OoO core: sits between the reorder buffer head and the ARF / LSQ.

---
 rtl/retire_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/retire_unit.sv
// In-order commit of up to two ROB head entries to the ARF, with store handoff to the LSQ.
// rob_pop is combinational; ARF writes and the retire pulse are registered. Stores stall commit until store_done.
module retire_unit #(
  parameter int XLEN          = 32,
  parameter int PREG_W        = 6,
  parameter int STORE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              head0_valid,
  input  logic              head0_complete,
  input  logic [XLEN-1:0]   head0_pc,
  input  logic [PREG_W-1:0] head0_dr_p,
  input  logic [PREG_W-1:0] head0_old_dr_p,
  input  logic [XLEN-1:0]   head0_data,
  input  logic              head0_reg_write,
  input  logic              head0_is_store,
  input  logic              head1_valid,
  input  logic              head1_complete,
  input  logic [XLEN-1:0]   head1_pc,
  input  logic [PREG_W-1:0] head1_dr_p,
  input  logic [PREG_W-1:0] head1_old_dr_p,
  input  logic [XLEN-1:0]   head1_data,
  input  logic              head1_reg_write,
  input  logic              head1_is_store,
  input  logic              store_done,
  input  logic              halt_in,
  output logic [1:0]        rob_pop,
  output logic [PREG_W-1:0] write_addr1,
  output logic [XLEN-1:0]   write_data1,
  output logic [PREG_W-1:0] old_addr1,
  output logic [PREG_W-1:0] write_addr2,
  output logic [XLEN-1:0]   write_data2,
  output logic [PREG_W-1:0] old_addr2,
  output logic [1:0]        write_en,
  output logic [XLEN-1:0]   pcRet,
  output logic              retire,
  output logic [31:0]       retired_count,
  output logic              store_err,
  output logic              done
);

  localparam int CNT_W = $clog2(STORE_TIMEOUT + 1);

  typedef enum logic {RUN, ST_WAIT} state_t;

  state_t           state, state_nxt;
  logic             en_q;
  logic [CNT_W-1:0] to_cnt;
  logic             r0, pop0, pop1, st_start, st_pop;

  // head1_pc is carried for symmetry with head0; slot 1 never hands a store to the LSQ.
  logic unused_head1_pc;
  assign unused_head1_pc = ^head1_pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (st_start)   state_nxt = ST_WAIT;
      ST_WAIT: if (store_done) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // en_q holds commit off until the first edge after reset release.
  always_comb begin
    r0       = head0_valid & head0_complete & en_q & ~done;
    pop0     = 1'b0;
    pop1     = 1'b0;
    st_start = 1'b0;
    st_pop   = 1'b0;
    case (state)
      RUN: begin
        pop0     = r0 & ~head0_is_store;
        pop1     = pop0 & head1_valid & head1_complete & ~head1_is_store;
        st_start = r0 & head0_is_store;
      end
      ST_WAIT: st_pop = store_done;
      default: ;
    endcase
    rob_pop = pop1 ? 2'd2 : ((pop0 | st_pop) ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q          <= 1'b0;
      write_addr1   <= '0;
      write_data1   <= '0;
      old_addr1     <= '0;
      write_addr2   <= '0;
      write_data2   <= '0;
      old_addr2     <= '0;
      write_en      <= '0;
      pcRet         <= '0;
      retire        <= 1'b0;
      retired_count <= '0;
      store_err     <= 1'b0;
      done          <= 1'b0;
      to_cnt        <= '0;
    end else begin
      en_q          <= 1'b1;
      write_addr1   <= head0_dr_p;
      write_data1   <= head0_data;
      old_addr1     <= head0_old_dr_p;
      write_addr2   <= head1_dr_p;
      write_data2   <= head1_data;
      old_addr2     <= head1_old_dr_p;
      write_en      <= {pop1 & head1_reg_write & (|head1_dr_p),
                        pop0 & head0_reg_write & (|head0_dr_p)};
      retire        <= st_start;
      if (st_start) pcRet <= head0_pc;
      retired_count <= retired_count + 32'(rob_pop);
      if (halt_in & ~head0_valid & (state == RUN) & en_q) done <= 1'b1;
      // Counter saturates at the timeout so a very late store_done is still accepted.
      if (state == ST_WAIT) begin
        if (store_done) begin
          to_cnt <= '0;
        end else if (to_cnt != CNT_W'(STORE_TIMEOUT)) begin
          to_cnt <= to_cnt + CNT_W'(1);
          if (to_cnt + CNT_W'(1) == CNT_W'(STORE_TIMEOUT)) store_err <= 1'b1;
        end
      end
    end
  end

endmodule
